// File: rtl/uart_loader.sv
// uart_loader: serial boot loader. Receives a little-endian word count N
// followed by N 32-bit words over an 8N1 UART line and writes them to RAM
// starting at word address 0. The core is held in reset until the image is
// complete. A failed load is sticky until the next reset.
// Optional build macro: UART_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte over every length and data byte, checked before the core is released.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_hold
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      N_MAX   = 32'd1 << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_CHK, LD_DONE, LD_ERR} ld_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam ld_state_t LD_AFTER = LD_CHK;
`else
    localparam ld_state_t LD_AFTER = LD_DONE;
`endif

    logic              rx_meta_r, rx_sync_r, rx_prev_r;
    logic              fall_s, tick_s;
    rx_state_t         rx_state_r, rx_state_s;
    logic [CNT_W-1:0]  clk_cnt_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r, byte_r;
    logic              byte_valid_r, frame_err_r, start_ok_r;

    ld_state_t         ld_state_r, ld_state_s;
    logic [1:0]        byte_cnt_r;
    logic [31:0]       asm_r, n_r, word_s;
    logic [ADDR_W:0]   word_cnt_r;
    logic              last_s, accept_s;
    logic              mem_we_r, busy_r, done_r, err_r, core_hold_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    assign fall_s   = rx_prev_r & ~rx_sync_r;
    assign word_s   = {byte_r, asm_r[31:8]};
    assign last_s   = ((32'(word_cnt_r) + 32'd1) == n_r);
    assign accept_s = byte_valid_r & ((ld_state_r == LD_LEN) | (ld_state_r == LD_DATA));

    // Two-flop synchronizer plus a history flop for start-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Bit receiver next state: sample mid-start, then every full bit period
    always_comb begin
        rx_state_s = rx_state_r;
        tick_s     = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (fall_s) rx_state_s = RX_START;
                else        rx_state_s = RX_IDLE;
            end
            RX_START: begin
                if (clk_cnt_r == HALF_M1) begin
                    tick_s = 1'b1;
                    if (rx_sync_r) rx_state_s = RX_IDLE;
                    else           rx_state_s = RX_DATA;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (clk_cnt_r == FULL_M1) begin
                    tick_s = 1'b1;
                    if (bit_idx_r == 3'd7) rx_state_s = RX_STOP;
                    else                   rx_state_s = RX_DATA;
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (clk_cnt_r == FULL_M1) begin
                    tick_s     = 1'b1;
                    rx_state_s = RX_IDLE;
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // Bit receiver datapath: bit timer, shift register and one-cycle byte pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r   <= RX_IDLE;
            clk_cnt_r    <= {CNT_W{1'b0}};
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            byte_r       <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            start_ok_r   <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            start_ok_r   <= 1'b0;
            if ((rx_state_r == RX_IDLE) || tick_s) clk_cnt_r <= {CNT_W{1'b0}};
            else                                   clk_cnt_r <= clk_cnt_r + CNT_W'(1);
            if (tick_s) begin
                case (rx_state_r)
                    RX_START: begin
                        bit_idx_r  <= 3'd0;
                        start_ok_r <= ~rx_sync_r;
                    end
                    RX_DATA: begin
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                    end
                    RX_STOP: begin
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= ~rx_sync_r;
                        byte_r       <= shift_r;
                    end
                    default: begin
                        bit_idx_r <= bit_idx_r;
                    end
                endcase
            end
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] chk_r;

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Running XOR over every length and data byte of the image
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          chk_r <= 8'd0;
        else if (accept_s) chk_r <= xor_fold(chk_r, byte_r);
        else               chk_r <= chk_r;
    end
`endif

    // Loader next state: length phase, word phase, then a terminal state
    always_comb begin
        ld_state_s = ld_state_r;
        case (ld_state_r)
            LD_LEN: begin
                if (frame_err_r) begin
                    ld_state_s = LD_ERR;
                end else if (byte_valid_r && (byte_cnt_r == 2'd3)) begin
                    if (word_s > N_MAX)       ld_state_s = LD_ERR;
                    else if (word_s == 32'd0) ld_state_s = LD_AFTER;
                    else                      ld_state_s = LD_DATA;
                end else begin
                    ld_state_s = LD_LEN;
                end
            end
            LD_DATA: begin
                if (frame_err_r)            ld_state_s = LD_ERR;
                else if (mem_we_r && last_s) ld_state_s = LD_AFTER;
                else                        ld_state_s = LD_DATA;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            LD_CHK: begin
                if (frame_err_r)       ld_state_s = LD_ERR;
                else if (byte_valid_r) ld_state_s = (byte_r == chk_r) ? LD_DONE : LD_ERR;
                else                   ld_state_s = LD_CHK;
            end
`endif
            LD_DONE: ld_state_s = LD_DONE;
            LD_ERR:  ld_state_s = LD_ERR;
            default: ld_state_s = LD_ERR;
        endcase
    end

    // Loader datapath: assemble bytes LSB first, capture N, issue RAM writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state_r  <= LD_LEN;
            byte_cnt_r  <= 2'd0;
            asm_r       <= 32'd0;
            n_r         <= 32'd0;
            word_cnt_r  <= {(ADDR_W+1){1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            ld_state_r <= ld_state_s;
            mem_we_r   <= 1'b0;
            if (accept_s) begin
                asm_r      <= word_s;
                byte_cnt_r <= byte_cnt_r + 2'd1;
                if (byte_cnt_r == 2'd3) begin
                    if (ld_state_r == LD_LEN) begin
                        n_r <= word_s;
                    end else begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= word_cnt_r[ADDR_W-1:0];
                        mem_wdata_r <= word_s;
                    end
                end
            end
            if (mem_we_r) word_cnt_r <= word_cnt_r + (ADDR_W+1)'(1);
        end
    end

    // Status flags follow the next loader state so they change with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            core_hold_r <= 1'b1;
        end else begin
            done_r      <= (ld_state_s == LD_DONE);
            err_r       <= (ld_state_s == LD_ERR);
            core_hold_r <= (ld_state_s != LD_DONE);
            if ((ld_state_s != LD_LEN) && (ld_state_s != LD_DATA))
                busy_r <= 1'b0;
            else if (start_ok_r && (ld_state_r == LD_LEN))
                busy_r <= 1'b1;
            else
                busy_r <= busy_r;
        end
    end

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign core_hold = core_hold_r;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: drives uart_loader through its rx pin with 8N1 frames and
// compares RAM writes and status flags against an image-level model.
module tb_uart_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, err, core_hold;

    uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
        .core_hold(core_hold)
    );

    always #5 clk = ~clk;

    int                checks_cnt = 0;
    int                fail_cnt   = 0;
    int unsigned       cyc = 0;
    int unsigned       last_we_cyc = 0;
    int unsigned       done_rise_cyc = 0;
    logic              done_prev = 1'b0;
    logic [AW+31:0]    wr_q[$];
    logic [7:0]        img_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Record every RAM write and the cycle done first rises, away from the active edge
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        done_prev <= done;
        if (done && !done_prev) done_rise_cyc <= cyc;
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            last_we_cyc <= cyc;
        end
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) img_q.push_back(w[8*i +: 8]);
    endtask

    task automatic send_img();
        for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i], 1'b1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check_val({tag, "_rst_we"},   {63'd0, mem_we},    64'd0);
        check_val({tag, "_rst_addr"}, {60'd0, mem_addr},  64'd0);
        check_val({tag, "_rst_data"}, {32'd0, mem_wdata}, 64'd0);
        check_val({tag, "_rst_busy"}, {63'd0, busy},      64'd0);
        check_val({tag, "_rst_done"}, {63'd0, done},      64'd0);
        check_val({tag, "_rst_err"},  {63'd0, err},       64'd0);
        check_val({tag, "_rst_hold"}, {63'd0, core_hold}, 64'd1);
        repeat (3) @(negedge clk);
        wr_q.delete();
        img_q.delete();
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Model: first 4 bytes give N; N > capacity fails, else word i goes to address i
    task automatic check_image(input string tag);
        logic [31:0]    n;
        logic [31:0]    w;
        logic [AW+31:0] e;
        int             nn;
        repeat (4 * CPB) @(negedge clk);
        n  = {img_q[3], img_q[2], img_q[1], img_q[0]};
        nn = (n > 32'(CAP)) ? 0 : int'(n);
        check_val({tag, "_wrcnt"}, 64'(wr_q.size()), 64'(nn));
        check_val({tag, "_done"},  {63'd0, done},      {63'd0, (n <= 32'(CAP))});
        check_val({tag, "_err"},   {63'd0, err},       {63'd0, (n > 32'(CAP))});
        check_val({tag, "_hold"},  {63'd0, core_hold}, {63'd0, (n > 32'(CAP))});
        check_val({tag, "_busy"},  {63'd0, busy},      64'd0);
        for (int i = 0; i < nn && i < wr_q.size(); i++) begin
            e = wr_q[i];
            w = {img_q[4*i+7], img_q[4*i+6], img_q[4*i+5], img_q[4*i+4]};
            check_val($sformatf("%s_addr%0d", tag, i), 64'(e[AW+31:32]), 64'(i));
            check_val($sformatf("%s_data%0d", tag, i), 64'(e[31:0]), 64'(w));
        end
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        repeat (3) @(negedge clk);

        // Two-word image, done exactly one cycle after the last write
        do_reset("t1");
        push_word(32'd2); push_word(32'h0000_0013); push_word(32'hDEAD_BEEF);
        send_img();
        check_image("t1");
        check_val("t1_done_lat", 64'(done_rise_cyc - last_we_cyc), 64'd1);

        // Empty image
        do_reset("t2");
        push_word(32'd0);
        send_img();
        check_image("t2");

        // Short low glitch, then a valid one-word image
        do_reset("t3");
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_val("t3_glitch_busy", {63'd0, busy}, 64'd0);
        push_word(32'd1); push_word(32'h1234_5678);
        send_img();
        check_image("t3");

        // Framing error is sticky and blocks a following image
        do_reset("t4");
        send_byte(8'h55, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        check_val("t4_err",  {63'd0, err},       64'd1);
        check_val("t4_busy", {63'd0, busy},      64'd0);
        check_val("t4_hold", {63'd0, core_hold}, 64'd1);
        push_word(32'd1); push_word(32'hA5A5_5A5A);
        send_img();
        repeat (4 * CPB) @(negedge clk);
        check_val("t4_nowr", 64'(wr_q.size()), 64'd0);
        check_val("t4_err2", {63'd0, err},     64'd1);
        check_val("t4_done", {63'd0, done},    64'd0);

        // Capacity boundaries: one over, far over (upper bits set), exactly full
        do_reset("t5a");
        push_word(32'(CAP + 1));
        send_img();
        check_image("t5a");
        do_reset("t5b");
        push_word(32'h0001_0000 + 32'd4);
        push_word(32'h1111_1111);
        send_img();
        check_image("t5b");
        do_reset("t5c");
        push_word(32'(CAP));
        for (int i = 0; i < CAP; i++) push_word($urandom);
        send_img();
        check_image("t5c");
        check_val("t5c_lastaddr", {60'd0, mem_addr}, 64'(CAP - 1));

        // Reset in the middle of an image, then reload from address 0
        do_reset("t6");
        push_word(32'd4); push_word(32'h0101_0101); push_word(32'h0202_0202);
        send_img();
        repeat (2 * CPB) @(negedge clk);
        check_val("t6_mid_wr",   64'(wr_q.size()), 64'd2);
        check_val("t6_mid_busy", {63'd0, busy},    64'd1);
        check_val("t6_mid_hold", {63'd0, core_hold}, 64'd1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        do_reset("t6b");
        push_word(32'd1); push_word(32'hCAFE_F00D);
        send_img();
        check_image("t6b");

        // Random images with trailing traffic that must be ignored
        for (int k = 0; k < 3; k++) begin
            do_reset($sformatf("r%0d", k));
            n = 32'($urandom_range(1, 5));
            push_word(n);
            for (int i = 0; i < int'(n); i++) push_word($urandom);
            img_q.push_back(8'($urandom));
            img_q.push_back(8'($urandom));
            send_img();
            check_image($sformatf("r%0d", k));
        end

        // Random oversize length
        do_reset("r_big");
        push_word(32'($urandom_range(CAP + 1, 32'h0000_FFFF)));
        send_img();
        check_image("r_big");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial boot loader that sits upstream of the SoC RAM and core.
- Receives a program image over the UART rx line and writes it word by word into instruction/data RAM from word address 0.
- Holds the core in reset until the image is complete.
- Replaces hex-file preloading on hardware; benches can drive it through the same rx pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); benches use 16
ADDR_W, 10, RAM word-address width; capacity 2^ADDR_W words

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
rx  input  1  UART serial in, idle high, 8N1, LSB first
mem_we  output  1  one-cycle RAM write strobe
mem_addr  output  ADDR_W  RAM word address
mem_wdata  output  32  RAM write data
busy  output  1  frame in progress (length or data phase)
done  output  1  image fully written; sticky
err  output  1  load failed; sticky
core_hold  output  1  keep core in reset; equals ~done

Behaviour:
- Reset (rst=0, async): all state cleared.
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, core_hold=1.
  - rx synchronizer flops reset to 1.
- rx passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Bit receiver states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized 1->0 edge.
  - START: wait CLKS_PER_BIT/2 cycles, sample. If sample=1 (glitch), return to IDLE with no byte and no error. Else go to DATA.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop=1: pulse byte_valid for 1 cycle with the byte, then IDLE.
    - Stop=0: framing error, go to ERROR.
- Frame format, all multi-byte fields little-endian:
  - 4-byte word count N.
  - N x 4-byte words.
- Loader states: LEN, DATA, DONE, ERROR.
  - Reset -> LEN. busy=1 from the first start bit accepted in LEN until leaving DATA.
  - LEN: after the 4th length byte, check N.
    - N > 2^ADDR_W: go to ERROR.
    - N = 0: go to DONE.
    - Otherwise: go to DATA, word_idx=0.
  - DATA: bytes assemble into a 32-bit word, byte 0 in bits [7:0].
    - On the 4th byte's byte_valid, mem_we=1 in the next cycle with mem_addr=word_idx and the assembled mem_wdata.
    - word_idx increments after the write.
    - mem_addr/mem_wdata hold their last values when mem_we=0.
  - After the write of word N-1, enter DONE in the following cycle: done=1, core_hold=0, busy=0.
  - DONE: terminal. Further rx traffic is ignored, no writes, done stays 1.
  - ERROR: err=1, busy=0, core_hold=1. Terminal; no further writes; rx ignored.
- Boundaries:
  - N = 2^ADDR_W is legal. The last write goes to address 2^ADDR_W-1; mem_addr never wraps.
  - Reset mid-byte or mid-image aborts the load and returns to LEN, address 0. A partial word is discarded.
  - Start-bit detection is edge-based, so back-to-back frames (stop bit directly followed by a start bit) are accepted.
  - byte_valid and the mem_we of the previous word never coincide: bytes are at least 10 bit times apart.
- Arithmetic: N is held in 32 bits. The comparison against 2^ADDR_W uses all 32 bits (no truncation).

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the last data word: the XOR of every length and data byte.
  - State CHK sits between DATA (or LEN when N=0) and DONE.
  - Match -> DONE. Mismatch -> ERROR.
  - Words are already written before the check, but core_hold stays 1 on mismatch.
- Undefined: no checksum byte; DATA/LEN go straight to DONE as described above.

Test Plan:
1. CLKS_PER_BIT=16. Send N=2, words 0x00000013 and 0xDEADBEEF -> two mem_we pulses (addr 0 data 0x00000013, addr 1 data 0xDEADBEEF); done=1 and core_hold=0 one cycle after the second pulse; err=0.
2. Send N=0 -> no mem_we; done=1 after the 4th length byte; core_hold=0.
3. Drive rx low for 3 cycles then high, then send a valid N=1 image with word 0x12345678 -> glitch ignored; single write addr 0 data 0x12345678; done=1.
4. Send one byte with stop bit forced 0 -> err=1, busy=0, core_hold=1. A following valid image produces no mem_we.
5. ADDR_W=10, N=0x00000401 -> err=1 with no writes. N=0x00000400 with 1024 words -> last write at addr 0x3FF, done=1.
6. Assert rst=0 after 2 of 4 words are written -> all outputs return to reset values. Reload N=1, word 0xCAFEF00D -> write at addr 0. With UART_LOADER_CHECKSUM_EN and a wrong checksum byte: err=1, core_hold=1.
